// File: rtl/mmio_gpio_bank_if.sv
// Processor io bus as seen by a memory-mapped peripheral.
// The master drives address, data and strobes; the slave returns combinational read data.
interface mmio_gpio_bank_if;
  logic [31:0] io_addr;
  logic [31:0] io_wr_val;
  logic        io_write_en;
  logic        io_read_en;
  logic        io_data_size;
  logic [31:0] io_rd_val;

  modport master (
    output io_addr, io_wr_val, io_write_en, io_read_en, io_data_size,
    input  io_rd_val
  );

  modport slave (
    input  io_addr, io_wr_val, io_write_en, io_read_en, io_data_size,
    output io_rd_val
  );
endinterface

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: debounced inputs with sticky rising-edge flags and an interrupt,
// plus an output register with atomic set/clear/toggle aliases.
module mmio_gpio_bank #(
  parameter logic [31:0] BASE_ADDR       = 32'h0002_0000,
  parameter int          N_IN            = 16,
  parameter int          N_OUT           = 16,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmio_gpio_bank_if.slave   io,
  input  logic [N_IN-1:0]   in_pins,
  output logic [N_OUT-1:0]  out_pins,
  output logic              irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic hit_in, hit_out, hit_set, hit_clr, hit_tgl, hit_edge, hit_en;

  assign hit_in   = (io.io_addr == BASE_ADDR);
  assign hit_out  = (io.io_addr == BASE_ADDR + 32'h04);
  assign hit_set  = (io.io_addr == BASE_ADDR + 32'h08);
  assign hit_clr  = (io.io_addr == BASE_ADDR + 32'h0C);
  assign hit_tgl  = (io.io_addr == BASE_ADDR + 32'h10);
  assign hit_edge = (io.io_addr == BASE_ADDR + 32'h14);
  assign hit_en   = (io.io_addr == BASE_ADDR + 32'h18);

  logic [N_OUT-1:0] out_reg;
  logic [N_IN-1:0]  edge_reg;
  logic [N_IN-1:0]  edge_en;
  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  sync;
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  w1c_mask;
  logic [N_IN-1:0]  sync_ff [SYNC_STAGES];
  logic [CW-1:0]    cnt     [N_IN];
  logic [N_OUT-1:0] wr_out;
  logic [N_IN-1:0]  wr_in;
  logic [31:0]      rd_val;

  // Size (io_data_size) is irrelevant because every access is a full word.
  logic unused_ok;
  assign unused_ok = ^{io.io_data_size, io.io_wr_val};

  assign wr_out = io.io_wr_val[N_OUT-1:0];
  assign wr_in  = io.io_wr_val[N_IN-1:0];
  assign sync   = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
    end else begin
      sync_ff[0] <= in_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
    end
  end

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    rise = '0;
    for (int i = 0; i < N_IN; i++)
      rise[i] = sync[i] & ~stable[i] & (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w1c_mask = (io.io_write_en && hit_edge) ? wr_in : '0;

  // A new rising edge is OR-ed in after the W1C so a same-cycle set survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= '0;
      edge_reg <= '0;
      edge_en  <= '0;
      irq      <= 1'b0;
    end else begin
      irq      <= |(edge_reg & edge_en);
      edge_reg <= (edge_reg & ~w1c_mask) | rise;
      if (io.io_write_en) begin
        if (hit_out) out_reg <= wr_out;
        if (hit_set) out_reg <= out_reg | wr_out;
        if (hit_clr) out_reg <= out_reg & ~wr_out;
        if (hit_tgl) out_reg <= out_reg ^ wr_out;
        if (hit_en)  edge_en <= wr_in;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (io.io_read_en) begin
      if (hit_in)   rd_val = 32'(stable);
      if (hit_out)  rd_val = 32'(out_reg);
      if (hit_edge) rd_val = 32'(edge_reg);
      if (hit_en)   rd_val = 32'(edge_en);
    end
  end

  assign io.io_rd_val = rd_val;
  assign out_pins     = out_reg;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: directed register-map scenarios followed by randomized bus and pin
// traffic, all checked every cycle against a window-based behavioural model.
module tb_mmio_gpio_bank;

  localparam logic [31:0] BASE  = 32'h0002_0000;
  localparam int          N_IN  = 16;
  localparam int          N_OUT = 16;
  localparam int          S     = 2;
  localparam int          D     = 8;

  localparam logic [31:0] A_IN   = BASE;
  localparam logic [31:0] A_OUT  = BASE + 32'h04;
  localparam logic [31:0] A_SET  = BASE + 32'h08;
  localparam logic [31:0] A_CLR  = BASE + 32'h0C;
  localparam logic [31:0] A_TGL  = BASE + 32'h10;
  localparam logic [31:0] A_EDGE = BASE + 32'h14;
  localparam logic [31:0] A_EN   = BASE + 32'h18;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_IN-1:0]  in_pins = '0;
  logic [N_OUT-1:0] out_pins;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  mmio_gpio_bank_if io ();

  mmio_gpio_bank #(
    .BASE_ADDR(BASE), .N_IN(N_IN), .N_OUT(N_OUT),
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .io(io),
    .in_pins(in_pins), .out_pins(out_pins), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: pin history per clock; a bit flips once its last D synchronised samples all disagree.
  logic [N_OUT-1:0] m_out = '0;
  logic [N_IN-1:0]  m_edge = '0, m_en = '0, m_stable = '0;
  logic             m_irq = 1'b0;
  logic [N_IN-1:0]  hist [S+D];
  logic [N_IN-1:0]  nh   [S+D];
  logic [N_IN-1:0]  new_stable, w1c;
  logic [N_OUT-1:0] d_out;
  logic             all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out <= '0; m_edge <= '0; m_en <= '0; m_stable <= '0; m_irq <= 1'b0;
      for (int j = 0; j < S + D; j++) hist[j] <= '0;
    end else begin
      nh[0] = in_pins;
      for (int j = 1; j < S + D; j++) nh[j] = hist[j-1];
      new_stable = m_stable;
      for (int i = 0; i < N_IN; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (nh[S+j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) new_stable[i] = ~m_stable[i];
      end
      w1c   = (io.io_write_en && io.io_addr == A_EDGE) ? io.io_wr_val[N_IN-1:0] : '0;
      d_out = io.io_wr_val[N_OUT-1:0];
      m_irq    <= |(m_edge & m_en);
      m_edge   <= (m_edge & ~w1c) | (new_stable & ~m_stable);
      m_stable <= new_stable;
      for (int j = 0; j < S + D; j++) hist[j] <= nh[j];
      if (io.io_write_en) begin
        case (io.io_addr)
          A_OUT:   m_out <= d_out;
          A_SET:   m_out <= m_out | d_out;
          A_CLR:   m_out <= m_out & ~d_out;
          A_TGL:   m_out <= m_out ^ d_out;
          A_EN:    m_en  <= io.io_wr_val[N_IN-1:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    if (!io.io_read_en) return 32'h0;
    case (io.io_addr)
      A_IN:    return 32'(m_stable);
      A_OUT:   return 32'(m_out);
      A_EDGE:  return 32'(m_edge);
      A_EN:    return 32'(m_en);
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("out_pins", 32'(out_pins), 32'(m_out));
    checkOutput("irq", 32'(irq), 32'(m_irq));
    checkOutput("io_rd_val", io.io_rd_val, exp_rd());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic we, input logic re);
    io.io_addr      = a;
    io.io_wr_val    = d;
    io.io_write_en  = we;
    io.io_read_en   = re;
    io.io_data_size = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Literal expectations pin both the DUT and the model's read value.
  task automatic expectRead(input string name, input logic [31:0] lit);
    checkOutput(name, io.io_rd_val, lit);
    checkOutput({name, "_model"}, exp_rd(), lit);
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(a, d, 1'b1, 1'b0);
    step();
    idle();
  endtask

  task automatic readAt(input logic [31:0] a, input logic [31:0] lit, input string name);
    applyStimulus(a, $urandom, 1'b0, 1'b1);
    @(negedge clk);
    expectRead(name, lit);
    step();
    idle();
  endtask

  logic [31:0] addrs [9];

  initial begin
    addrs = '{A_IN, A_OUT, A_SET, A_CLR, A_TGL, A_EDGE, A_EN, BASE + 32'h1C, 32'h0002_0100};
    idle();
    in_pins = 16'h00FF;
    step();
    step();
    @(negedge clk);
    checkOutput("rst_out_pins", 32'(out_pins), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    step();
    rst = 1'b0;

    applyStimulus(A_IN, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step();
      @(negedge clk);
      if (c == 9)  expectRead("in_after9", 32'h0);
      if (c == 10) expectRead("in_after10", 32'h0000_00FF);
    end
    step();
    readAt(A_EDGE, 32'h0000_00FF, "edge_after_rst");

    writeReg(A_OUT, 32'h0000_00F0);
    @(negedge clk); checkOutput("out_wr", 32'(out_pins), 32'h00F0);
    writeReg(A_SET, 32'h0000_000F);
    @(negedge clk); checkOutput("out_set", 32'(out_pins), 32'h00FF);
    writeReg(A_CLR, 32'h0000_0030);
    @(negedge clk); checkOutput("out_clr", 32'(out_pins), 32'h00CF);
    writeReg(A_TGL, 32'h0000_0101);
    @(negedge clk); checkOutput("out_tgl", 32'(out_pins), 32'h01CE);
    step();
    readAt(A_OUT, 32'h0000_01CE, "out_read");
    readAt(A_SET, 32'h0, "set_read");

    in_pins = '0;
    repeat (14) step();
    writeReg(A_EDGE, 32'hFFFF_FFFF);
    in_pins[3] = 1'b1;
    repeat (7) step();
    in_pins[3] = 1'b0;
    repeat (14) step();
    readAt(A_IN, 32'h0, "glitch_in");
    readAt(A_EDGE, 32'h0, "glitch_edge");

    writeReg(A_EN, 32'h0000_0008);
    in_pins[3] = 1'b1;
    applyStimulus(A_IN, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step();
      @(negedge clk);
      if (c == 9)  expectRead("in3_after9", 32'h0);
      if (c == 10) begin
        expectRead("in3_after10", 32'h0000_0008);
        checkOutput("irq_with_edge", 32'(irq), 32'h0);
      end
    end
    applyStimulus(A_EDGE, 32'h0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    expectRead("edge3", 32'h0000_0008);
    checkOutput("irq_next", 32'(irq), 32'h1);
    step();
    writeReg(A_EDGE, 32'h0000_0008);
    @(negedge clk); checkOutput("irq_hold", 32'(irq), 32'h1);
    step();
    @(negedge clk); checkOutput("irq_cleared", 32'(irq), 32'h0);
    step();

    in_pins[4] = 1'b1;
    repeat (12) step();
    readAt(A_EDGE, 32'h0000_0010, "edge4");
    @(negedge clk); checkOutput("irq_masked", 32'(irq), 32'h0);
    step();

    in_pins[5] = 1'b1;
    repeat (9) step();
    applyStimulus(A_EDGE, 32'h0000_0020, 1'b1, 1'b0);
    step();
    idle();
    readAt(A_EDGE, 32'h0000_0030, "w1c_race");

    readAt(BASE + 32'h1C, 32'h0, "unmapped_1c");
    readAt(32'h0002_0100, 32'h0, "unmapped_100");
    writeReg(32'h0002_0100, 32'hFFFF_FFFF);
    writeReg(BASE + 32'h1C, 32'hFFFF_FFFF);
    readAt(A_OUT, 32'h0000_01CE, "out_after_unmapped");
    readAt(A_EN, 32'h0000_0008, "en_after_unmapped");
    readAt(A_EDGE, 32'h0000_0030, "edge_after_unmapped");
    applyStimulus(A_IN, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    expectRead("in_no_read_en", 32'h0);
    step();

    for (int k = 0; k < 3000; k++) begin
      if ((k >= 600 && k < 900) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
        in_pins[$urandom_range(0, N_IN - 1)] ^= 1'b1;
      applyStimulus(addrs[$urandom_range(0, 8)], $urandom,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if (k == 1500) rst = 1'b1;
      if (k == 1503) rst = 1'b0;
      step();
    end
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
